// File: rtl/uart_rst_pkg.sv
// Shared definitions for the UART reset sequencer: state encoding, default
// stage timings and the counter sizing helper.
package uart_rst_pkg;

   localparam int DEF_STAGE_DLY = 4;
   localparam int DEF_HOLD_CYC  = 8;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_BAUD,
      WAIT_FIFO,
      WAIT_TXRX,
      RUN,
      SOFT_HOLD
   } seq_state_t;

   // Width of a down-counter able to hold the larger of the two delays.
   function automatic int cnt_width(input int stage_dly, input int hold_cyc);
      return $clog2(((stage_dly > hold_cyc) ? stage_dly : hold_cyc) + 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second rising clock edge after reset falls.
module reset_sync (
   input  logic clk,
   input  logic reset,
   output logic sync_rst
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta     <= 1'b1;
         sync_rst <= 1'b1;
      end else begin
         meta     <= 1'b0;
         sync_rst <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the UART domains (baud, FIFOs, TX/RX) with a
// soft-reset request path; all outputs come straight from flops.
module reset_sequencer
   import uart_rst_pkg::*;
#(
   parameter int STAGE_DLY = DEF_STAGE_DLY,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic soft_rst_req,
   output logic rst_baud,
   output logic rst_fifo,
   output logic rst_tx,
   output logic rst_rx,
   output logic seq_done,
   output logic soft_rst_ack
);

   localparam int CW = cnt_width(STAGE_DLY, HOLD_CYC);

   // The edge on which HOLD notices sync_rst low already counts as the first
   // cycle of the baud wait, hence the shortened first load.
   localparam logic [CW-1:0] STAGE_LOAD = CW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] FIRST_LOAD = CW'((STAGE_DLY > 1) ? (STAGE_DLY - 2) : 0);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
   localparam bit            SKIP_BAUD  = (STAGE_DLY == 1);

   logic          sync_rst;
   seq_state_t    state;
   seq_state_t    state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          ack_next;
   logic          baud_next;
   logic          fifo_next;
   logic          txrx_next;
   logic          done_next;

   reset_sync u_reset_sync (
      .clk      (clk),
      .reset    (reset),
      .sync_rst (sync_rst)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= HOLD;
         cnt          <= '0;
         rst_baud     <= 1'b1;
         rst_fifo     <= 1'b1;
         rst_tx       <= 1'b1;
         rst_rx       <= 1'b1;
         seq_done     <= 1'b0;
         soft_rst_ack <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         rst_baud     <= baud_next;
         rst_fifo     <= fifo_next;
         rst_tx       <= txrx_next;
         rst_rx       <= txrx_next;
         seq_done     <= done_next;
         soft_rst_ack <= ack_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      ack_next   = 1'b0;

      unique case (state)
         HOLD: begin
            if (!sync_rst) begin
               if (SKIP_BAUD) begin
                  state_next = WAIT_FIFO;
                  cnt_next   = STAGE_LOAD;
               end else begin
                  state_next = WAIT_BAUD;
                  cnt_next   = FIRST_LOAD;
               end
            end
         end
         WAIT_BAUD: begin
            if (cnt == '0) begin
               state_next = WAIT_FIFO;
               cnt_next   = STAGE_LOAD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         WAIT_FIFO: begin
            if (cnt == '0) begin
               state_next = WAIT_TXRX;
               cnt_next   = STAGE_LOAD;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         WAIT_TXRX: begin
            if (cnt == '0) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         RUN: begin
            if (soft_rst_req) begin
               state_next = SOFT_HOLD;
               cnt_next   = HOLD_LOAD;
               ack_next   = 1'b1;
            end
         end
         SOFT_HOLD: begin
            // Returning through HOLD replays the power-on release timing.
            if (cnt == '0) begin
               state_next = HOLD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: begin
            state_next = HOLD;
            cnt_next   = '0;
         end
      endcase

      if (sync_rst) begin
         state_next = HOLD;
         cnt_next   = '0;
         ack_next   = 1'b0;
      end
   end

   // Output flops are loaded from the next-state decode so each release lands
   // on the same edge as the corresponding state transition.
   always_comb begin
      baud_next = (state_next == HOLD) || (state_next == WAIT_BAUD) ||
                  (state_next == SOFT_HOLD);
      fifo_next = (state_next != WAIT_TXRX) && (state_next != RUN);
      txrx_next = (state_next != RUN);
      done_next = (state_next == RUN);
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default and minimum-parameter instances,
// table-driven release timing plus hand-written reset-pulse and held-request cases.
module tb_reset_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic soft_rst_req;
   logic soft_rst_req_min;

   logic rst_baud, rst_fifo, rst_tx, rst_rx, seq_done, soft_rst_ack;
   logic rst_baud_m, rst_fifo_m, rst_tx_m, rst_rx_m, seq_done_m, soft_rst_ack_m;

   typedef struct {
      int         edge_no;
      logic       req;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   edge_n;
   int   checks;
   int   failures;

   always #5 clk = ~clk;

   reset_sequencer #(.STAGE_DLY(4), .HOLD_CYC(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .soft_rst_req (soft_rst_req),
      .rst_baud     (rst_baud),
      .rst_fifo     (rst_fifo),
      .rst_tx       (rst_tx),
      .rst_rx       (rst_rx),
      .seq_done     (seq_done),
      .soft_rst_ack (soft_rst_ack)
   );

   reset_sequencer #(.STAGE_DLY(1), .HOLD_CYC(1)) dut_min (
      .clk          (clk),
      .reset        (reset),
      .soft_rst_req (soft_rst_req_min),
      .rst_baud     (rst_baud_m),
      .rst_fifo     (rst_fifo_m),
      .rst_tx       (rst_tx_m),
      .rst_rx       (rst_rx_m),
      .seq_done     (seq_done_m),
      .soft_rst_ack (soft_rst_ack_m)
   );

   // Packed as {baud, fifo, tx, rx, done, ack}.
   function automatic logic [5:0] outs(input bit sel);
      if (sel)
         return {rst_baud_m, rst_fifo_m, rst_tx_m, rst_rx_m, seq_done_m, soft_rst_ack_m};
      return {rst_baud, rst_fifo, rst_tx, rst_rx, seq_done, soft_rst_ack};
   endfunction

   task automatic step();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic power_on();
      reset            = 1'b1;
      soft_rst_req     = 1'b0;
      soft_rst_req_min = 1'b0;
      repeat (3) step();
      edge_n = 0;
      reset  = 1'b0;
   endtask

   task automatic apply_stimulus(input bit sel, input int last_edge);
      int idx;
      for (int e = 1; e <= last_edge; e++) begin
         idx = -1;
         for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].edge_no == e) idx = i;
         if (sel) soft_rst_req_min = (idx >= 0) ? vecs[idx].req : 1'b0;
         else     soft_rst_req     = (idx >= 0) ? vecs[idx].req : 1'b0;
         step();
         if (idx >= 0)
            check_output($sformatf("dut%0d edge %0d", sel, e),
                         {26'b0, outs(sel)}, {26'b0, vecs[idx].exp});
      end
      soft_rst_req     = 1'b0;
      soft_rst_req_min = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acks;
      checks   = 0;
      failures = 0;
      edge_n   = 0;

      // Power-on, ignored request at edge 8, soft reset at edge 20.
      power_on();
      check_output("reset state", {26'b0, outs(0)}, {26'b0, 6'b111100});
      check_output("reset state min", {26'b0, outs(1)}, {26'b0, 6'b111100});
      vecs.delete();
      vecs.push_back('{5,  1'b0, 6'b111100});
      vecs.push_back('{6,  1'b0, 6'b011100});
      vecs.push_back('{8,  1'b1, 6'b011100});
      vecs.push_back('{9,  1'b0, 6'b011100});
      vecs.push_back('{10, 1'b0, 6'b001100});
      vecs.push_back('{13, 1'b0, 6'b001100});
      vecs.push_back('{14, 1'b0, 6'b000010});
      vecs.push_back('{19, 1'b0, 6'b000010});
      vecs.push_back('{20, 1'b1, 6'b111101});
      vecs.push_back('{21, 1'b0, 6'b111100});
      vecs.push_back('{31, 1'b0, 6'b111100});
      vecs.push_back('{32, 1'b0, 6'b011100});
      vecs.push_back('{35, 1'b0, 6'b011100});
      vecs.push_back('{36, 1'b0, 6'b001100});
      vecs.push_back('{39, 1'b0, 6'b001100});
      vecs.push_back('{40, 1'b0, 6'b000010});
      vecs.push_back('{41, 1'b0, 6'b000010});
      apply_stimulus(1'b0, 42);

      // Minimum parameters: one-cycle stages and one-cycle soft hold.
      power_on();
      vecs.delete();
      vecs.push_back('{2,  1'b0, 6'b111100});
      vecs.push_back('{3,  1'b0, 6'b011100});
      vecs.push_back('{4,  1'b0, 6'b001100});
      vecs.push_back('{5,  1'b0, 6'b000010});
      vecs.push_back('{9,  1'b0, 6'b000010});
      vecs.push_back('{10, 1'b1, 6'b111101});
      vecs.push_back('{11, 1'b0, 6'b111100});
      vecs.push_back('{12, 1'b0, 6'b011100});
      vecs.push_back('{13, 1'b0, 6'b001100});
      vecs.push_back('{14, 1'b0, 6'b000010});
      apply_stimulus(1'b1, 15);

      // Sub-cycle reset pulse between edges 7 and 8 restarts the sequence.
      power_on();
      repeat (7) step();
      check_output("pre-pulse edge 7", {26'b0, outs(0)}, {26'b0, 6'b011100});
      #3;
      reset = 1'b1;
      #1;
      check_output("async assert", {26'b0, outs(0)}, {26'b0, 6'b111100});
      #2;
      reset = 1'b0;
      step();
      check_output("pulse edge 8", {26'b0, outs(0)}, {26'b0, 6'b111100});
      repeat (4) step();
      check_output("pulse edge 12", {26'b0, outs(0)}, {26'b0, 6'b111100});
      step();
      check_output("pulse edge 13", {26'b0, outs(0)}, {26'b0, 6'b011100});
      repeat (4) step();
      check_output("pulse edge 17", {26'b0, outs(0)}, {26'b0, 6'b001100});
      repeat (3) step();
      check_output("pulse edge 20", {26'b0, outs(0)}, {26'b0, 6'b001100});
      step();
      check_output("pulse edge 21", {26'b0, outs(0)}, {26'b0, 6'b000010});

      // Request held high across edges 20..35 gives a single acknowledge.
      power_on();
      repeat (19) step();
      soft_rst_req = 1'b1;
      acks = 0;
      for (int e = 20; e <= 45; e++) begin
         if (e == 36) soft_rst_req = 1'b0;
         step();
         if (soft_rst_ack === 1'b1) acks++;
         if (e == 20) check_output("held edge 20", {26'b0, outs(0)}, {26'b0, 6'b111101});
         if (e == 32) check_output("held edge 32", {26'b0, outs(0)}, {26'b0, 6'b011100});
         if (e == 39) check_output("held edge 39", {26'b0, outs(0)}, {26'b0, 6'b001100});
         if (e == 40) check_output("held edge 40", {26'b0, outs(0)}, {26'b0, 6'b000010});
         if (e == 45) check_output("held edge 45", {26'b0, outs(0)}, {26'b0, 6'b000010});
      end
      check_output("held ack count", acks, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
